// File: rtl/tdm_pkg.sv
// Shared types for the 4-way TDM link (used by the tdm_mux4 transmitter and the tdm_demux4 receiver).
package tdm_pkg;

    typedef enum logic {S_HUNT, S_LOCKED} tdm_state_t;
    typedef logic [1:0] tdm_slot_t;

    localparam int        TDM_LANES     = 4;
    localparam tdm_slot_t TDM_LAST_SLOT = 2'd3;

    // One-hot lane strobe for a given slot position.
    function automatic logic [TDM_LANES-1:0] slot_onehot(input tdm_slot_t slot);
        logic [TDM_LANES-1:0] w_hot;
        w_hot       = '0;
        w_hot[slot] = 1'b1;
        return w_hot;
    endfunction

endpackage

// File: rtl/tdm_demux4_slot_counter.sv
// 2-bit wrapping slot position counter; load forces slot 1 because the loading word is always slot 0.
module slot_counter
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_load,
    output logic [1:0] o_slot
);

    tdm_slot_t r_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot <= 2'd1;
        end else if (i_en) begin
            r_slot <= r_slot + 2'd1;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4-way TDM link: aligns on frame_sync and routes slot words to four registered lanes.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         valid_in,
    input  logic         frame_sync,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] out0,
    output logic [N-1:0] out1,
    output logic [N-1:0] out2,
    output logic [N-1:0] out3,
    output logic [3:0]   out_valid,
    output logic         frame_done,
    output logic         locked,
    output logic         sync_error
);

    tdm_state_t             r_state;
    logic [N-1:0]           r_lane [TDM_LANES];
    logic [TDM_LANES-1:0]   r_out_valid;
    logic                   r_frame_done;
    logic                   r_locked;
    logic                   r_sync_error;

    logic                   w_accept;
    logic                   w_load;
    logic                   w_advance;
    logic [1:0]             w_slot;

    assign w_accept  = ena && valid_in;
    assign w_load    = w_accept && frame_sync;
    assign w_advance = w_accept && !frame_sync && (r_state == S_LOCKED);

    slot_counter u_slot_counter (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_advance),
        .i_load (w_load),
        .o_slot (w_slot)
    );

    // Strobes default low each cycle; a sync word always lands in lane 0, flagged if it broke a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_error <= 1'b0;
            for (int k = 0; k < TDM_LANES; k++) begin
                r_lane[k] <= '0;
            end
        end else begin
            r_out_valid  <= '0;
            r_frame_done <= 1'b0;
            r_sync_error <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_HUNT: begin
                        if (frame_sync) begin
                            r_lane[0]   <= data_in;
                            r_out_valid <= slot_onehot(2'd0);
                            r_locked    <= 1'b1;
                            r_state     <= S_LOCKED;
                        end
                    end
                    S_LOCKED: begin
                        if (frame_sync) begin
                            r_lane[0]    <= data_in;
                            r_out_valid  <= slot_onehot(2'd0);
                            r_sync_error <= (w_slot != 2'd0);
                        end else begin
                            r_lane[w_slot] <= data_in;
                            r_out_valid    <= slot_onehot(w_slot);
                            r_frame_done   <= (w_slot == TDM_LAST_SLOT);
                        end
                    end
                    default: begin
                        r_state <= S_HUNT;
                    end
                endcase
            end
        end
    end

    assign out0       = r_lane[0];
    assign out1       = r_lane[1];
    assign out2       = r_lane[2];
    assign out3       = r_lane[3];
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign locked     = r_locked;
    assign sync_error = r_sync_error;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed vector table, hand-written reset sequences, random traffic vs. a frame model.
module tb_tdm_demux4;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         validIn;
    logic         frameSync;
    logic [N-1:0] dataIn;
    logic [N-1:0] out0, out1, out2, out3;
    logic [3:0]   outValid;
    logic         frameDone;
    logic         locked;
    logic         syncError;

    int checks = 0;
    int errors = 0;

    // Frame-level model of the receiver
    bit mLocked;
    int mSlot;
    int mLane [4];
    int mOv;
    bit mFd;
    bit mSe;

    typedef struct {
        int en, v, s, d;
        int o0, o1, o2, o3;
        int ov, fd, lk, se;
    } vec_t;

    vec_t vecs [$];

    tdm_demux4 #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .valid_in   (validIn),
        .frame_sync (frameSync),
        .data_in    (dataIn),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (outValid),
        .frame_done (frameDone),
        .locked     (locked),
        .sync_error (syncError)
    );

    always #5 clk = ~clk;

    function automatic void compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        mLocked = 0;
        mSlot   = 0;
        mOv     = 0;
        mFd     = 0;
        mSe     = 0;
        for (int k = 0; k < 4; k++) mLane[k] = 0;
    endfunction

    function automatic void modelStep(input int e, input int v, input int s, input int d);
        mOv = 0;
        mFd = 0;
        mSe = 0;
        if (e != 0 && v != 0) begin
            if (s != 0) begin
                mSe      = mLocked && (mSlot != 0);
                mLane[0] = d;
                mOv      = 1;
                mSlot    = 1;
                mLocked  = 1;
            end else if (mLocked) begin
                mLane[mSlot] = d;
                mOv          = 1 << mSlot;
                mFd          = (mSlot == 3);
                mSlot        = (mSlot + 1) % 4;
            end
        end
    endfunction

    function automatic vec_t mk(input int en, v, s, d, o0, o1, o2, o3, ov, fd, lk, se);
        vec_t r;
        r.en = en; r.v = v; r.s = s; r.d = d;
        r.o0 = o0; r.o1 = o1; r.o2 = o2; r.o3 = o3;
        r.ov = ov; r.fd = fd; r.lk = lk; r.se = se;
        return r;
    endfunction

    task automatic applyStimulus(input int e, input int v, input int s, input int d);
        ena       = (e != 0);
        validIn   = (v != 0);
        frameSync = (s != 0);
        dataIn    = N'(d);
        @(posedge clk);
        modelStep(e, v, s, d);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, " out0"},       int'(out0),      mLane[0]);
        compare({tag, " out1"},       int'(out1),      mLane[1]);
        compare({tag, " out2"},       int'(out2),      mLane[2]);
        compare({tag, " out3"},       int'(out3),      mLane[3]);
        compare({tag, " out_valid"},  int'(outValid),  mOv);
        compare({tag, " frame_done"}, int'(frameDone), int'(mFd));
        compare({tag, " locked"},     int'(locked),    int'(mLocked));
        compare({tag, " sync_error"}, int'(syncError), int'(mSe));
    endtask

    task automatic checkVector(input int idx, input vec_t t);
        string tag;
        tag = $sformatf("vec%0d", idx);
        compare({tag, " out0"},       int'(out0),      t.o0);
        compare({tag, " out1"},       int'(out1),      t.o1);
        compare({tag, " out2"},       int'(out2),      t.o2);
        compare({tag, " out3"},       int'(out3),      t.o3);
        compare({tag, " out_valid"},  int'(outValid),  t.ov);
        compare({tag, " frame_done"}, int'(frameDone), t.fd);
        compare({tag, " locked"},     int'(locked),    t.lk);
        compare({tag, " sync_error"}, int'(syncError), t.se);
    endtask

    // Raise rst between clock edges and confirm outputs clear before the next edge.
    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        compare({tag, " async out0"},      int'(out0),     0);
        compare({tag, " async out1"},      int'(out1),     0);
        compare({tag, " async out2"},      int'(out2),     0);
        compare({tag, " async out3"},      int'(out3),     0);
        compare({tag, " async out_valid"}, int'(outValid), 0);
        compare({tag, " async locked"},    int'(locked),   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput({tag, " post"});
    endtask

    initial begin
        rst       = 1'b1;
        ena       = 1'b0;
        validIn   = 1'b0;
        frameSync = 1'b0;
        dataIn    = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        compare("reset frame_done", int'(frameDone), 0);
        rst = 1'b0;

        //              en v s d   o0 o1 o2 o3 ov fd lk se
        vecs.push_back(mk(1,1,0,3, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,2, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,1,0, 0,0,0,0, 1,0,1,0));
        vecs.push_back(mk(1,1,0,1, 0,1,0,0, 2,0,1,0));
        vecs.push_back(mk(1,1,0,2, 0,1,2,0, 4,0,1,0));
        vecs.push_back(mk(1,1,0,3, 0,1,2,3, 8,1,1,0));
        vecs.push_back(mk(1,1,1,3, 3,1,2,3, 1,0,1,0));
        vecs.push_back(mk(1,0,0,1, 3,1,2,3, 0,0,1,0));
        vecs.push_back(mk(1,1,0,2, 3,2,2,3, 2,0,1,0));
        vecs.push_back(mk(1,0,1,1, 3,2,2,3, 0,0,1,0));
        vecs.push_back(mk(1,1,0,1, 3,2,1,3, 4,0,1,0));
        vecs.push_back(mk(1,0,0,1, 3,2,1,3, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0, 3,2,1,0, 8,1,1,0));
        vecs.push_back(mk(1,1,0,1, 1,2,1,0, 1,0,1,0));
        vecs.push_back(mk(1,1,0,3, 1,3,1,0, 2,0,1,0));
        vecs.push_back(mk(1,1,1,1, 1,3,1,0, 1,0,1,1));
        vecs.push_back(mk(1,1,0,2, 1,2,1,0, 2,0,1,0));
        vecs.push_back(mk(0,1,0,3, 1,2,1,0, 0,0,1,0));
        vecs.push_back(mk(0,0,1,3, 1,2,1,0, 0,0,1,0));
        vecs.push_back(mk(0,1,1,0, 1,2,1,0, 0,0,1,0));
        vecs.push_back(mk(0,0,0,3, 1,2,1,0, 0,0,1,0));
        vecs.push_back(mk(0,1,0,3, 1,2,1,0, 0,0,1,0));
        vecs.push_back(mk(1,1,0,3, 1,2,3,0, 4,0,1,0));
        vecs.push_back(mk(1,1,0,1, 1,2,3,1, 8,1,1,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].v, vecs[i].s, vecs[i].d);
            checkVector(i, vecs[i]);
            checkOutput($sformatf("vec%0d model", i));
        end

        asyncReset("midcycle");

        applyStimulus(1, 1, 1, 2);
        applyStimulus(1, 1, 0, 1);
        checkOutput("relock");
        compare("relock out1", int'(out1), 1);
        asyncReset("midframe");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, (i + 1) % 4);
            compare($sformatf("hunt%0d locked", i), int'(locked), 0);
            compare($sformatf("hunt%0d out_valid", i), int'(outValid), 0);
            checkOutput($sformatf("hunt%0d", i));
        end

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                asyncReset($sformatf("rand%0d", i));
            end
            applyStimulus(($urandom_range(0, 7) != 0) ? 1 : 0,
                          ($urandom_range(0, 3) != 0) ? 1 : 0,
                          ($urandom_range(0, 9) == 0) ? 1 : 0,
                          int'($urandom_range(0, 3)));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of a 4-way time-division link: a transmit-side 4:1 mux places lane 0..3 words on one shared N-bit bus in a fixed slot order (0,1,2,3,0,...), and this block routes them back to four registered lanes.
- Tracks slot position with a 2-bit counter and aligns to a frame_sync marker on slot 0.
- Flags misalignment and raises per-lane and per-frame strobes for downstream logic.

Parameters:
- N, 2, width of each data word and output lane.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; low freezes all state, and all strobe outputs are 0
- valid_in  input  1  data_in holds a slot word this cycle
- frame_sync  input  1  marks the current valid word as slot 0; ignored when valid_in=0
- data_in  input  N  shared TDM bus word
- out0, out1, out2, out3  output  N each  registered lane words; hold until overwritten
- out_valid  output  4  one-cycle strobe; bit k=1 the cycle after outk was updated
- frame_done  output  1  one-cycle strobe; slot 3 was captured in the previous cycle
- locked  output  1  1 when aligned to a frame
- sync_error  output  1  one-cycle strobe; frame_sync arrived on a slot other than 0 while locked

Behaviour:
- Reset is asynchronous, active-high: clk and rst as in the rest of the design; assertion takes effect immediately, independent of clk.
- On reset: out0..out3=0, out_valid=0, frame_done=0, locked=0, sync_error=0, slot=0, state=S_HUNT.
- The "accept" event is ena && valid_in on a rising edge. Nothing changes without an accept, except that strobes clear to 0.
- All outputs are registered. Latency from an accepted word to its outk/out_valid is 1 cycle.
- State S_HUNT:
  - Accept with frame_sync=0: word discarded; no strobes; stays in S_HUNT.
  - Accept with frame_sync=1: out0<=data_in, out_valid=0001, slot<=1, locked<=1, go to S_LOCKED.
- State S_LOCKED, accept with frame_sync=0:
  - out[slot]<=data_in, out_valid bit slot=1.
  - slot<=slot+1 modulo 4; wraps 3->0 with no gap.
  - frame_done=1 if the captured slot was 3.
- State S_LOCKED, accept with frame_sync=1 and slot==0: normal capture to out0; no error.
- State S_LOCKED, accept with frame_sync=1 and slot!=0 (resync):
  - sync_error=1; the word is treated as slot 0.
  - out0<=data_in, out_valid=0001, slot<=1, frame_done=0; stays locked.
  - Partial-frame lanes keep their last values.
- Exactly one out_valid bit is high per accept in S_LOCKED. At most one strobe of each kind per cycle.
- ena=0 mid-frame: slot and lanes hold; the frame resumes at the same slot when ena returns.
- valid_in gaps (bubbles) do not advance slot.
- rst mid-frame: immediate return to reset values; realignment requires a new frame_sync.
- locked never drops except on rst.
- No arithmetic beyond the 2-bit slot counter; lane data is passed through unmodified.

Decomposition:
- Shared package tdm_pkg:
  - typedef enum logic {S_HUNT, S_LOCKED} tdm_state_t
  - typedef logic [1:0] tdm_slot_t
  - localparam TDM_LANES = 4
  - The transmit-side tdm_mux4 scheduler uses the same package.
- One natural sub-module: slot_counter, a 2-bit wrapping counter with enable and synchronous load-to-1.
- Lane registers, state register and strobes stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with prior nonzero lanes -> all outputs 0 and locked=0 immediately, without waiting for a clk edge.
- Hunt then lock: valid words 3,2 without sync, then sync+0,1,2,3 (N=2) -> the first two are ignored. Then out0..out3=0,1,2,3, with out_valid 0001,0010,0100,1000 on successive cycles and frame_done high only after slot 3. Also check locked=1.
- Wrap and bubbles: second frame 3,2,1,0 with valid_in=0 bubbles between words and sync on the first word -> out0..out3=3,2,1,0. No strobes during bubbles, no sync_error.
- Resync: locked at slot 2, apply sync with data 1 -> sync_error=1 one cycle, out0=1, out_valid=0001. The next word lands in out1, and out2/out3 keep their old values.
- Enable freeze: deassert ena after slot 1 for 5 cycles while toggling valid_in/data_in -> no output changes, all strobes 0. The next accepted word lands in slot 2.
- Reset mid-frame: rst at slot 2, release, send valid words without sync -> stays in S_HUNT with locked=0 and out_valid always 0000.
